// File: rtl/pc_fetch_stack.sv
// Program counter and fetch stage with a LIFO hardware return stack for JAL/RET.
// The PC, stack pointer and sticky flags are registered; opcode and target are decoded straight from instr.
module pc_fetch_stack #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     s_inc,
    input  logic                     s_jal,
    input  logic                     s_ret,
    input  logic [INSTR_W-1:0]       instr,
    output logic [PC_W-1:0]          pc,
    output logic [5:0]               opcode,
    output logic [PC_W-1:0]          target,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     ovf,
    output logic                     unf
);

    localparam int SP_W = $clog2(DEPTH) + 1;
    localparam int IX_W = SP_W - 1;

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [SP_W-1:0] sp_r;
    logic [SP_W-1:0] sp_nxt_s;
    logic [SP_W-1:0] sp_dec_s;
    logic            ovf_r;
    logic            ovf_nxt_s;
    logic            unf_r;
    logic            unf_nxt_s;
    logic            push_s;
    logic [PC_W-1:0] stack_r [DEPTH];

    assign opcode   = instr[INSTR_W-1 -: 6];
    assign target   = instr[PC_W-1:0];
    assign pc_inc_s = pc_r + PC_W'(1);
    assign sp_dec_s = sp_r - SP_W'(1);

    assign pc  = pc_r;
    assign sp  = sp_r;
    assign ovf = ovf_r;
    assign unf = unf_r;

    // Next-state selection; ret beats jal beats inc/jump, and a stall holds everything.
    always_comb begin
        pc_nxt_s  = pc_r;
        sp_nxt_s  = sp_r;
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        push_s    = 1'b0;
        if (en) begin
            if (s_ret) begin
                if (sp_r != SP_W'(0)) begin
                    pc_nxt_s = stack_r[sp_dec_s[IX_W-1:0]];
                    sp_nxt_s = sp_dec_s;
                end else begin
                    unf_nxt_s = 1'b1;
                    pc_nxt_s  = pc_inc_s;
                end
            end else if (s_jal) begin
                pc_nxt_s = target;
                if (sp_r != SP_W'(DEPTH)) begin
                    push_s   = 1'b1;
                    sp_nxt_s = sp_r + SP_W'(1);
                end else begin
                    ovf_nxt_s = 1'b1;
                end
            end else if (s_inc) begin
                pc_nxt_s = pc_inc_s;
            end else begin
                pc_nxt_s = target;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC, stack pointer and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= PC_W'(0);
            sp_r  <= SP_W'(0);
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            sp_r  <= sp_nxt_s;
            ovf_r <= ovf_nxt_s;
            unf_r <= unf_nxt_s;
        end
    end

    // Return-address storage; contents are meaningless after reset, so no clear is needed.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            stack_r[sp_r[IX_W-1:0]] <= pc_inc_s;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stack.sv
// Directed table-driven bench for pc_fetch_stack plus hand sequences for the deep call chain.
module tb_pc_fetch_stack;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       inc;
        logic       jal;
        logic       ret;
        logic [9:0] tgt;
        logic [9:0] pc;
        logic [3:0] sp;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, en, s_inc, s_jal, s_ret;
    logic [15:0] instr;
    logic [9:0]  pc, target;
    logic [5:0]  opcode;
    logic [3:0]  sp;
    logic        ovf, unf;

    int   n_pass = 0;
    int   n_tot  = 0;
    logic [5:0] op_cnt = 6'd0;
    vec_t tbl [21];
    logic [9:0] tgts [9];
    logic [9:0] pushed [8];

    always #5 clk = ~clk;

    pc_fetch_stack dut (
        .clk(clk), .reset(reset), .en(en), .s_inc(s_inc), .s_jal(s_jal), .s_ret(s_ret),
        .instr(instr), .pc(pc), .opcode(opcode), .target(target), .sp(sp), .ovf(ovf), .unf(unf)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic e, input logic i, input logic j,
                                input logic r, input logic [9:0] t, input logic [9:0] p,
                                input logic [3:0] s, input logic o, input logic u);
        vec_t v;
        v = {rst, e, i, j, r, t, p, s, o, u};
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm);
        reset = v.rst; en = v.en; s_inc = v.inc; s_jal = v.jal; s_ret = v.ret;
        op_cnt = op_cnt + 6'd1;
        instr = {op_cnt, v.tgt};
        #1;
        check({nm, ".opcode"}, 32'(opcode), 32'(op_cnt));
        check({nm, ".target"}, 32'(target), 32'(v.tgt));
        @(posedge clk);
        #1;
        check({nm, ".pc"},  32'(pc),  32'(v.pc));
        check({nm, ".sp"},  32'(sp),  32'(v.sp));
        check({nm, ".ovf"}, 32'(ovf), 32'(v.ovf));
        check({nm, ".unf"}, 32'(unf), 32'(v.unf));
    endtask

    initial begin
        //           rst   en    inc   jal   ret   tgt      pc       sp    ovf   unf
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h155, 10'h000, 4'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h155, 10'h001, 4'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0AA, 10'h002, 4'd0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3C3, 10'h003, 4'd0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h02A, 10'h02A, 4'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h005, 10'h005, 4'd0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h100, 10'h100, 4'd1, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h2F0, 10'h006, 4'd0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 4'd0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h111, 10'h000, 4'd0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 4'd0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h020, 10'h020, 4'd1, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h077, 10'h020, 4'd1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h078, 10'h020, 4'd1, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h079, 10'h020, 4'd1, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h07A, 10'h020, 4'd1, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h077, 10'h000, 4'd0, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h077, 10'h001, 4'd0, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h300, 10'h002, 4'd0, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h300, 10'h003, 4'd0, 1'b0, 1'b1);
        tbl[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h300, 10'h000, 4'd0, 1'b0, 1'b0);

        reset = 1'b1; en = 1'b0; s_inc = 1'b0; s_jal = 1'b0; s_ret = 1'b0; instr = 16'h0000;
        for (int i = 0; i < 21; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Nine nested calls from pc=0 into an eight-deep stack.
        for (int i = 0; i < 9; i++) tgts[i] = 10'(10'h100 + i * 10'h010 + i);
        pushed[0] = 10'h001;
        for (int k = 1; k < 8; k++) pushed[k] = tgts[k-1] + 10'h001;
        for (int i = 0; i < 9; i++)
            run(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tgts[i], tgts[i],
                   (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 1'b0), $sformatf("call%0d", i));
        for (int i = 0; i < 8; i++)
            run(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3AB, pushed[7-i],
                   4'(7 - i), 1'b1, 1'b0), $sformatf("ret%0d", i));
        run(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3AB, 10'h002, 4'd0, 1'b1, 1'b1), "ret_unf");

        // Reset in the middle of a call chain discards the stack and flags.
        run(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h050, 10'h050, 4'd1, 1'b1, 1'b1), "chain0");
        run(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h060, 10'h060, 4'd2, 1'b1, 1'b1), "chain1");
        run(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h070, 10'h000, 4'd0, 1'b0, 1'b0), "mid_rst");
        run(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h070, 10'h001, 4'd0, 1'b0, 1'b1), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
